// File: rtl/mem_access_stage.sv
// MEM-stage data-SRAM access unit: store lane steering, multi-cycle loads with extension, ALU pass-through.
// Optional misaligned-address exceptions are enabled by defining MEM_ADDR_EXC_EN.
module mem_access_stage #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] mem_result,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        adel,
    output logic        ades
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    // A latency of 4 truncates to 0, which the 2-bit counter reaches after wrapping 1,2,3,0.
    localparam logic [1:0] LAT_MATCH = 2'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] result_q;
    logic [1:0]  lane_q;
    logic [3:0]  op_q;

    logic        is_load;
    logic        is_store;
    logic        mis_load;
    logic        mis_store;
    logic [31:0] rdata_ext_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (mem_op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load  = in_valid;
            OP_SB, OP_SH, OP_SW:                 is_store = in_valid;
            default: ;
        endcase
    end

`ifdef MEM_ADDR_EXC_EN
    always_comb begin
        mis_load  = 1'b0;
        mis_store = 1'b0;
        if (in_valid) begin
            case (mem_op)
                OP_LH, OP_LHU: mis_load  = alu_result[0];
                OP_LW:         mis_load  = |alu_result[1:0];
                OP_SH:         mis_store = alu_result[0];
                OP_SW:         mis_store = |alu_result[1:0];
                default: ;
            endcase
        end
    end
`else
    assign mis_load  = 1'b0;
    assign mis_store = 1'b0;
`endif

    // Extraction uses the lane and opcode latched when the request was issued.
    always_comb begin
        byte_sel = data_sram_rdata[8*lane_q +: 8];
        half_sel = lane_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (op_q)
            OP_LB:   rdata_ext_d = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  rdata_ext_d = {24'd0, byte_sel};
            OP_LH:   rdata_ext_d = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  rdata_ext_d = {16'd0, half_sel};
            default: rdata_ext_d = data_sram_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            result_q <= 32'd0;
            lane_q   <= 2'd0;
            op_q     <= 4'd0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_load && !mis_load) begin
                        state_q <= WAIT;
                        cnt_q   <= 2'd1;
                        lane_q  <= alu_result[1:0];
                        op_q    <= mem_op;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAT_MATCH) begin
                        result_q <= rdata_ext_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= 2'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall           = 1'b0;
        out_valid       = 1'b0;
        mem_result      = alu_result;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'd0;
        data_sram_addr  = {alu_result[31:2], 2'b00};
        data_sram_wdata = 32'd0;
        adel            = 1'b0;
        ades            = 1'b0;
        case (state_q)
            IDLE: begin
                out_valid = in_valid;
                if (mis_load) begin
                    adel = 1'b1;
                end else if (mis_store) begin
                    ades = 1'b1;
                end else if (is_store) begin
                    data_sram_en = 1'b1;
                    case (mem_op)
                        OP_SB: begin
                            data_sram_wen   = 4'b0001 << alu_result[1:0];
                            data_sram_wdata = {4{store_data[7:0]}};
                        end
                        OP_SH: begin
                            data_sram_wen   = alu_result[1] ? 4'b1100 : 4'b0011;
                            data_sram_wdata = {2{store_data[15:0]}};
                        end
                        default: begin
                            data_sram_wen   = 4'b1111;
                            data_sram_wdata = store_data;
                        end
                    endcase
                end else if (is_load) begin
                    data_sram_en = 1'b1;
                    stall        = 1'b1;
                    out_valid    = 1'b0;
                end
            end
            WAIT: begin
                stall = 1'b1;
            end
            DONE: begin
                out_valid  = 1'b1;
                mem_result = result_q;
            end
            default: ;
        endcase
        if (flush) begin
            stall         = 1'b0;
            out_valid     = 1'b0;
            data_sram_en  = 1'b0;
            data_sram_wen = 4'd0;
            adel          = 1'b0;
            ades          = 1'b0;
        end
        if (!rst) begin
            stall           = 1'b0;
            out_valid       = 1'b0;
            data_sram_en    = 1'b0;
            data_sram_wen   = 4'd0;
            data_sram_addr  = 32'd0;
            data_sram_wdata = 32'd0;
            adel            = 1'b0;
            ades            = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one instance at read latency 1, one at read latency 3.
module tb_mem_access_stage;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        a_valid, a_flush, a_stall, a_ovalid, a_en, a_adel, a_ades;
    logic [3:0]  a_op, a_wen;
    logic [31:0] a_alu, a_sd, a_rdata, a_res, a_addr, a_wdata;

    logic        b_valid, b_flush, b_stall, b_ovalid, b_en, b_adel, b_ades;
    logic [3:0]  b_op, b_wen;
    logic [31:0] b_alu, b_sd, b_rdata, b_res, b_addr, b_wdata;

    mem_access_stage #(.RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .mem_op(a_op), .alu_result(a_alu),
        .store_data(a_sd), .flush(a_flush), .stall(a_stall), .out_valid(a_ovalid),
        .mem_result(a_res), .data_sram_en(a_en), .data_sram_wen(a_wen),
        .data_sram_addr(a_addr), .data_sram_wdata(a_wdata), .data_sram_rdata(a_rdata),
        .adel(a_adel), .ades(a_ades)
    );

    mem_access_stage #(.RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .mem_op(b_op), .alu_result(b_alu),
        .store_data(b_sd), .flush(b_flush), .stall(b_stall), .out_valid(b_ovalid),
        .mem_result(b_res), .data_sram_en(b_en), .data_sram_wen(b_wen),
        .data_sram_addr(b_addr), .data_sram_wdata(b_wdata), .data_sram_rdata(b_rdata),
        .adel(b_adel), .ades(b_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load on the latency-1 instance; correct rdata is presented only in the capture cycle.
    task automatic load_a(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp);
        a_valid = 1'b1; a_op = op; a_alu = addr; a_rdata = 32'h0;
        #1 chk({tag, "_req_stall"}, {31'd0, a_stall}, 32'd1);
        chk({tag, "_req_en"}, {31'd0, a_en}, 32'd1);
        tick;
        a_rdata = rd;
        #1 chk({tag, "_wait_stall"}, {31'd0, a_stall}, 32'd1);
        tick;
        a_rdata = 32'h0;
        #1 chk({tag, "_done_valid"}, {31'd0, a_ovalid}, 32'd1);
        chk({tag, "_done_result"}, a_res, exp);
        tick;
    endtask

    initial begin
        rst = 1'b0;
        a_valid = 1'b1; a_op = 4'd0; a_alu = 32'h55; a_sd = 32'h0; a_flush = 1'b0; a_rdata = 32'h0;
        b_valid = 1'b0; b_op = 4'd0; b_alu = 32'h0;  b_sd = 32'h0; b_flush = 1'b0; b_rdata = 32'h0;

        #1;
        chk("rst_out_valid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_stall", {31'd0, a_stall}, 32'd0);
        chk("rst_en", {31'd0, a_en}, 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_mem_result", a_res, 32'h55);
        repeat (2) tick;
        rst = 1'b1;

        // ALU pass-through
        a_valid = 1'b1; a_op = 4'd0; a_alu = 32'h1234;
        #1 chk("alu_valid", {31'd0, a_ovalid}, 32'd1);
        chk("alu_result", a_res, 32'h1234);
        chk("alu_stall", {31'd0, a_stall}, 32'd0);
        chk("alu_en", {31'd0, a_en}, 32'd0);
        tick;

        a_valid = 1'b0; a_op = 4'd5; a_alu = 32'h40;
        #1 chk("novalid_en", {31'd0, a_en}, 32'd0);
        chk("novalid_out_valid", {31'd0, a_ovalid}, 32'd0);
        tick;

        a_valid = 1'b1; a_op = 4'd7; a_alu = 32'h77;
        #1 chk("badop_en", {31'd0, a_en}, 32'd0);
        chk("badop_result", a_res, 32'h77);
        tick;

        // Stores
        a_op = 4'd8; a_alu = 32'h1003; a_sd = 32'h000000AB;
        #1 chk("sb_en", {31'd0, a_en}, 32'd1);
        chk("sb_wen", {28'd0, a_wen}, 32'h8);
        chk("sb_addr", a_addr, 32'h1000);
        chk("sb_wdata", a_wdata, 32'hABABABAB);
        chk("sb_stall", {31'd0, a_stall}, 32'd0);
        chk("sb_out_valid", {31'd0, a_ovalid}, 32'd1);
        tick;

        a_op = 4'd9; a_alu = 32'h1002; a_sd = 32'h1234CDEF;
        #1 chk("sh_wen", {28'd0, a_wen}, 32'hC);
        chk("sh_wdata", a_wdata, 32'hCDEFCDEF);
        tick;

        a_op = 4'd10; a_alu = 32'h1004; a_sd = 32'hDEADBEEF;
        #1 chk("sw_wen", {28'd0, a_wen}, 32'hF);
        chk("sw_wdata", a_wdata, 32'hDEADBEEF);
        tick;

        // LB with detailed per-cycle checks
        a_op = 4'd1; a_alu = 32'h2002; a_rdata = 32'hDEADBEEF;
        #1 chk("lb_T_stall", {31'd0, a_stall}, 32'd1);
        chk("lb_T_en", {31'd0, a_en}, 32'd1);
        chk("lb_T_wen", {28'd0, a_wen}, 32'd0);
        chk("lb_T_out_valid", {31'd0, a_ovalid}, 32'd0);
        chk("lb_T_addr", a_addr, 32'h2000);
        tick;
        a_rdata = 32'h00800000;
        #1 chk("lb_T1_stall", {31'd0, a_stall}, 32'd1);
        chk("lb_T1_en", {31'd0, a_en}, 32'd0);
        chk("lb_T1_out_valid", {31'd0, a_ovalid}, 32'd0);
        tick;
        a_rdata = 32'h0;
        #1 chk("lb_T2_out_valid", {31'd0, a_ovalid}, 32'd1);
        chk("lb_T2_result", a_res, 32'hFFFFFF80);
        chk("lb_T2_stall", {31'd0, a_stall}, 32'd0);
        tick;

        load_a("lbu", 4'd2, 32'h2002, 32'h00800000, 32'h00000080);
        load_a("lh",  4'd3, 32'h2002, 32'h80011234, 32'hFFFF8001);
        load_a("lhu", 4'd4, 32'h2000, 32'h8001F234, 32'h0000F234);
        load_a("lw",  4'd5, 32'h2004, 32'h12345678, 32'h12345678);

        // Misaligned accesses
`ifdef MEM_ADDR_EXC_EN
        a_op = 4'd5; a_alu = 32'h3002;
        #1 chk("mis_lw_adel", {31'd0, a_adel}, 32'd1);
        chk("mis_lw_en", {31'd0, a_en}, 32'd0);
        chk("mis_lw_stall", {31'd0, a_stall}, 32'd0);
        chk("mis_lw_out_valid", {31'd0, a_ovalid}, 32'd1);
        chk("mis_lw_result", a_res, 32'h3002);
        tick;
        a_op = 4'd9; a_alu = 32'h3001; a_sd = 32'h1111;
        #1 chk("mis_sh_ades", {31'd0, a_ades}, 32'd1);
        chk("mis_sh_adel", {31'd0, a_adel}, 32'd0);
        chk("mis_sh_en", {31'd0, a_en}, 32'd0);
        tick;
        a_op = 4'd0; a_alu = 32'h5;
        #1 chk("mis_after_ades", {31'd0, a_ades}, 32'd0);
        chk("mis_after_adel", {31'd0, a_adel}, 32'd0);
        tick;
`else
        a_op = 4'd5; a_alu = 32'h3002; a_rdata = 32'h0;
        #1 chk("mis_lw_adel", {31'd0, a_adel}, 32'd0);
        chk("mis_lw_en", {31'd0, a_en}, 32'd1);
        chk("mis_lw_addr", a_addr, 32'h3000);
        tick;
        a_rdata = 32'hCAFEF00D;
        tick;
        a_rdata = 32'h0;
        #1 chk("mis_lw_result", a_res, 32'hCAFEF00D);
        tick;
        a_op = 4'd9; a_alu = 32'h3001; a_sd = 32'h1111;
        #1 chk("mis_sh_ades", {31'd0, a_ades}, 32'd0);
        chk("mis_sh_wen", {28'd0, a_wen}, 32'h3);
        tick;
`endif

        // Flush on the second WAIT cycle, latency 3
        a_valid = 1'b0; a_op = 4'd0;
        b_valid = 1'b1; b_op = 4'd5; b_alu = 32'h40; b_rdata = 32'h0;
        #1 chk("fl_T_stall", {31'd0, b_stall}, 32'd1);
        tick;
        #1 chk("fl_W1_stall", {31'd0, b_stall}, 32'd1);
        tick;
        b_flush = 1'b1;
        #1 chk("fl_W2_stall", {31'd0, b_stall}, 32'd0);
        chk("fl_W2_out_valid", {31'd0, b_ovalid}, 32'd0);
        chk("fl_W2_en", {31'd0, b_en}, 32'd0);
        tick;
        b_flush = 1'b0; b_op = 4'd0; b_alu = 32'h99;
        #1 chk("fl_next_valid", {31'd0, b_ovalid}, 32'd1);
        chk("fl_next_result", b_res, 32'h99);
        chk("fl_next_stall", {31'd0, b_stall}, 32'd0);
        tick;

        // Full LW at latency 3: data valid only in cycle T+3
        b_op = 4'd5; b_alu = 32'h44; b_rdata = 32'h0;
        #1 chk("l3_T_en", {31'd0, b_en}, 32'd1);
        tick;
        tick;
        #1 chk("l3_T2_stall", {31'd0, b_stall}, 32'd1);
        tick;
        b_rdata = 32'h13579BDF;
        #1 chk("l3_T3_stall", {31'd0, b_stall}, 32'd1);
        chk("l3_T3_out_valid", {31'd0, b_ovalid}, 32'd0);
        tick;
        b_rdata = 32'h0;
        #1 chk("l3_T4_out_valid", {31'd0, b_ovalid}, 32'd1);
        chk("l3_T4_result", b_res, 32'h13579BDF);
        chk("l3_T4_stall", {31'd0, b_stall}, 32'd0);
        tick;
        b_valid = 1'b0; b_op = 4'd0;

        // Asynchronous reset in the middle of WAIT
        a_valid = 1'b1; a_op = 4'd1; a_alu = 32'h2002;
        tick;
        #2;
        rst = 1'b0;
        #1 chk("arst_stall", {31'd0, a_stall}, 32'd0);
        chk("arst_en", {31'd0, a_en}, 32'd0);
        chk("arst_out_valid", {31'd0, a_ovalid}, 32'd0);
        a_valid = 1'b0; a_op = 4'd0;
        tick;
        rst = 1'b1;
        tick;
        a_valid = 1'b1; a_op = 4'd0; a_alu = 32'h7;
        #1 chk("arst_after_valid", {31'd0, a_ovalid}, 32'd1);
        chk("arst_after_result", a_res, 32'h7);
        chk("arst_after_stall", {31'd0, a_stall}, 32'd0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-SRAM access unit between the EX/MEM pipeline register and mem_wb.
- Drives the data SRAM for loads and stores: byte-lane alignment, write strobes, load sign/zero extension.
- Stalls upstream for the SRAM read latency.
- Passes non-memory ALU results straight through, so mem_wb always receives the correct writeback value.

Parameters:
- RD_LATENCY, 1, SRAM read latency in cycles, from the request edge to valid data_sram_rdata (legal range 1..4).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  EX/MEM holds a valid instruction.
- mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 8 SB, 9 SH, 10 SW; any other code is treated as none.
- alu_result  in  32  effective address for memory ops; result for all other ops.
- store_data  in  32  rt value for stores.
- flush  in  1  abandon the current instruction.
- stall  out  1  hold EX/MEM and upstream stages.
- out_valid  out  1  mem_result is valid for mem_wb this cycle.
- mem_result  out  32  value to mem_wb memResult.
- data_sram_en  out  1  SRAM request strobe.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  word-aligned address, {alu_result[31:2],2'b00}.
- data_sram_wdata  out  32  lane-replicated store data.
- data_sram_rdata  in  32  SRAM read data.
- adel  out  1  load address error (optional feature only).
- ades  out  1  store address error (optional feature only).

Behaviour:
- FSM states: IDLE, WAIT, DONE. Also a 2-bit latency counter and a 32-bit result_q register.
- Reset (rst=0, asynchronous): state IDLE, counter 0, result_q 0. Every output except mem_result is 0 while reset is held. mem_result is combinational (see IDLE rule below).
- IDLE, non-memory op or in_valid=0:
  - stall=0, data_sram_en=0, data_sram_wen=0.
  - out_valid=in_valid, mem_result=alu_result. Zero latency.
- IDLE, store (in_valid=1):
  - Same cycle: data_sram_en=1, stall=0, out_valid=1, mem_result=alu_result. State stays IDLE.
  - SB: wen=1<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: wen=addr[1]?4'b1100:4'b0011, wdata={2{store_data[15:0]}}.
  - SW: wen=4'b1111, wdata=store_data.
- IDLE, load (in_valid=1):
  - Same cycle (T): data_sram_en=1, wen=0, stall=1, out_valid=0. Next state WAIT, counter=1.
- WAIT:
  - stall=1, data_sram_en=0, out_valid=0.
  - Counter increments each cycle.
  - When counter==RD_LATENCY: capture the extended rdata into result_q; next state DONE.
  - With RD_LATENCY=1, the capture occurs in cycle T+1.
- DONE:
  - stall=0, out_valid=1, mem_result=result_q. Next state IDLE.
  - Upstream advances at this edge, so the same load is never reissued.
- Load extraction, with lane=addr[1:0] latched at request time:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: halfword at addr[1], sign- or zero-extended.
  - LW: full word.
- Total load latency: request edge to out_valid is RD_LATENCY+1 cycles.
- Upstream holds in_valid, mem_op, alu_result and store_data stable while stall=1. The latched lane/op are used regardless.
- flush=1:
  - Any state goes to IDLE on the next edge. out_valid and data_sram_en are forced 0 that cycle; stall=0.
  - In-flight rdata is discarded.
  - flush has priority over every other event.
- Without the optional feature, misaligned LH/LW/SH/SW silently ignore the low address bits as specified above; adel=ades=0.

Optional Feature:
- MEM_ADDR_EXC_EN defined:
  - Misaligned accesses are detected in IDLE with in_valid=1: LH/LHU with addr[0]=1, LW with addr[1:0]!=0, SH with addr[0]=1, SW with addr[1:0]!=0.
  - On a misaligned access: data_sram_en=0, no stall, out_valid=1, mem_result=alu_result (the BadVAddr), and a one-cycle pulse on adel (loads) or ades (stores).
- MEM_ADDR_EXC_EN undefined: adel/ades tied 0; no detection logic.

Test Plan:
- Reset: hold rst=0 mid-WAIT -> state IDLE, stall=0, data_sram_en=0, out_valid=0 immediately (asynchronous).
- ALU op: in_valid=1, mem_op=0, alu_result=0x1234 -> same cycle out_valid=1, mem_result=0x1234, stall=0, data_sram_en=0.
- SB to 0x1003, store_data=0xAB -> data_sram_en=1, wen=4'b1000, addr=0x1000, wdata=0xABABABAB, stall=0.
- LB from 0x2002, rdata=0x00800000, RD_LATENCY=1 -> stall=1 for 2 cycles, then out_valid=1, mem_result=0xFFFFFF80; LBU same -> 0x00000080.
- LW with RD_LATENCY=3 and flush asserted on the second WAIT cycle -> IDLE next edge, out_valid never asserted, next instruction issues normally.
- MEM_ADDR_EXC_EN defined: LW at 0x3002 -> adel=1 for one cycle, data_sram_en=0, mem_result=0x3002; SH at 0x3001 -> ades=1.
